// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED alarm sequencer: FSM states, register map,
// CTRL bit positions and the saturating remaining-count helper.
package led_seq_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned REPEAT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_A   = 3'd1,
        WAIT_A = 3'd2,
        WR_B   = 3'd3,
        WAIT_B = 3'd4,
        WR_OFF = 3'd5
    } state_e;

    localparam logic [ADDR_W-1:0] REG_CTRL    = 2'd0;
    localparam logic [ADDR_W-1:0] REG_PERIOD  = 2'd1;
    localparam logic [ADDR_W-1:0] REG_PATTERN = 2'd2;
    localparam logic [ADDR_W-1:0] REG_REPEAT  = 2'd3;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_AUTO  = 1;
    localparam int unsigned CTRL_IE    = 2;
    localparam int unsigned CTRL_START = 3;
    localparam int unsigned CTRL_STOP  = 4;

    localparam int unsigned PATTERN_B_LSB = 16;
    localparam int unsigned STAT_BUSY     = 31;
    localparam int unsigned STAT_DONE     = 30;

    // Persistent CTRL fields; start/stop are pulses and are never stored.
    typedef struct packed {
        logic ie;
        logic auto_arm;
        logic enable;
    } ctrl_t;

    function automatic logic [REPEAT_W-1:0] sat_dec(input logic [REPEAT_W-1:0] v);
        return (v == '0) ? '0 : v - REPEAT_W'(1);
    endfunction

endpackage

// File: rtl/led_seq_timer.sv
// Loadable down-counter timing one pattern phase; expire_c_o pulses on the
// last enabled cycle, so a load of N gives exactly N enabled cycles.
module led_seq_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? '0 : load_val_i - CNT_W'(1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/led_alarm_sequencer.sv
// Avalon-MM LED alarm sequencer: config slave window plus a master that writes
// the A/B blink pattern (and a final dark write) into the LED PIO data register.
module led_alarm_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned LED_W      = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = 25000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_chipselect,
    input  logic              s_write_n,
    input  logic [DATA_W-1:0] s_writedata,
    output logic [DATA_W-1:0] s_readdata,
    input  logic              alarm_trig,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [DATA_W-1:0] m_writedata,
    output logic              busy,
    output logic              irq
);

    state_e              state_q, state_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [LED_W-1:0]    pat_a_q, pat_a_d;
    logic [LED_W-1:0]    pat_b_q, pat_b_d;
    logic [REPEAT_W-1:0] repeat_q, repeat_d;
    logic [REPEAT_W-1:0] remaining_q, remaining_d;
    logic                done_q, done_d;
    logic                alarm_q;
    logic                m_cs_q, m_cs_d;
    logic                m_wr_n_q, m_wr_n_d;
    logic [LED_W-1:0]    m_wd_q, m_wd_d;
    logic                busy_q, busy_d;
    logic                irq_q, irq_d;

    logic                cfg_wr;
    logic                start_pulse;
    logic                stop_pulse;
    logic                alarm_rise;
    logic                start_cond;
    logic                abort;
    logic [REPEAT_W-1:0] rem_dec;
    logic                tmr_load;
    logic                tmr_en;
    logic                tmr_expire;
    logic                unused_wdata;

    assign cfg_wr      = s_chipselect && !s_write_n;
    assign start_pulse = cfg_wr && (s_address == REG_CTRL) && s_writedata[CTRL_START];
    assign stop_pulse  = cfg_wr && (s_address == REG_CTRL) && s_writedata[CTRL_STOP];
    assign alarm_rise  = alarm_trig && !alarm_q;
    assign rem_dec     = sat_dec(remaining_q);
    assign unused_wdata = ^s_writedata;

    // Timer reloads from PERIOD during each write cycle, counts during waits.
    assign tmr_load = (state_q == WR_A) || (state_q == WR_B);
    assign tmr_en   = (state_q == WAIT_A) || (state_q == WAIT_B);

    led_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (period_q),
        .en_i       (tmr_en),
        .expire_c_o (tmr_expire)
    );

    // Register writes, sequencing FSM and registered master-side outputs.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        period_d    = period_q;
        pat_a_d     = pat_a_q;
        pat_b_d     = pat_b_q;
        repeat_d    = repeat_q;
        remaining_d = remaining_q;
        done_d      = done_q;
        m_wd_d      = m_wd_q;
        start_cond  = 1'b0;
        abort       = 1'b0;

        if (cfg_wr) begin
            case (s_address)
                REG_CTRL: begin
                    ctrl_d.enable   = s_writedata[CTRL_EN];
                    ctrl_d.auto_arm = s_writedata[CTRL_AUTO];
                    ctrl_d.ie       = s_writedata[CTRL_IE];
                end
                REG_PERIOD: begin
                    period_d = (s_writedata[CNT_W-1:0] == '0) ? CNT_W'(1)
                                                               : s_writedata[CNT_W-1:0];
                end
                REG_PATTERN: begin
                    pat_a_d = s_writedata[LED_W-1:0];
                    pat_b_d = s_writedata[PATTERN_B_LSB +: LED_W];
                end
                REG_REPEAT: begin
                    repeat_d = s_writedata[REPEAT_W-1:0];
                    done_d   = 1'b0;
                end
                default: ;
            endcase
        end

        // Stop beats start in the same write; enable uses the post-write value.
        start_cond = ctrl_d.enable && !stop_pulse
                     && (start_pulse || (ctrl_d.auto_arm && alarm_rise));
        abort      = stop_pulse || !ctrl_d.enable;

        case (state_q)
            IDLE: begin
                if (start_cond) begin
                    state_d     = WR_A;
                    remaining_d = repeat_d;
                    done_d      = 1'b0;
                end
            end
            WR_A:   state_d = abort ? WR_OFF : WAIT_A;
            WAIT_A: begin
                if (abort) begin
                    state_d = WR_OFF;
                end else if (tmr_expire) begin
                    state_d = WR_B;
                end
            end
            WR_B:   state_d = abort ? WR_OFF : WAIT_B;
            WAIT_B: begin
                // A pair that reached its B wait is counted even when aborted.
                if (abort || tmr_expire) begin
                    if (repeat_q != '0) begin
                        remaining_d = rem_dec;
                    end
                    if (abort || ((repeat_q != '0) && (rem_dec == '0))) begin
                        state_d = WR_OFF;
                    end else begin
                        state_d = WR_A;
                    end
                end
            end
            WR_OFF: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        m_cs_d = (state_d == WR_A) || (state_d == WR_B) || (state_d == WR_OFF);
        m_wr_n_d = !m_cs_d;
        case (state_d)
            WR_A:    m_wd_d = pat_a_q;
            WR_B:    m_wd_d = pat_b_q;
            WR_OFF:  m_wd_d = '0;
            default: m_wd_d = m_wd_q;
        endcase
        busy_d = (state_d != IDLE);
        irq_d  = done_d && ctrl_d.ie;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            period_q    <= CNT_W'(DEF_PERIOD);
            pat_a_q     <= '0;
            pat_b_q     <= '0;
            repeat_q    <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
            m_cs_q      <= 1'b0;
            m_wr_n_q    <= 1'b1;
            m_wd_q      <= '0;
            busy_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            period_q    <= period_d;
            pat_a_q     <= pat_a_d;
            pat_b_q     <= pat_b_d;
            repeat_q    <= repeat_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            alarm_q     <= alarm_trig;
            m_cs_q      <= m_cs_d;
            m_wr_n_q    <= m_wr_n_d;
            m_wd_q      <= m_wd_d;
            busy_q      <= busy_d;
            irq_q       <= irq_d;
        end
    end

    // Zero-wait-state read mux; unused bits read as zero.
    always_comb begin
        s_readdata = '0;
        case (s_address)
            REG_CTRL: begin
                s_readdata[CTRL_EN]   = ctrl_q.enable;
                s_readdata[CTRL_AUTO] = ctrl_q.auto_arm;
                s_readdata[CTRL_IE]   = ctrl_q.ie;
            end
            REG_PERIOD:  s_readdata[CNT_W-1:0] = period_q;
            REG_PATTERN: begin
                s_readdata[LED_W-1:0]               = pat_a_q;
                s_readdata[PATTERN_B_LSB +: LED_W]  = pat_b_q;
            end
            REG_REPEAT: begin
                s_readdata[STAT_BUSY]      = busy_q;
                s_readdata[STAT_DONE]      = done_q;
                s_readdata[REPEAT_W-1:0]   = remaining_q;
            end
            default: s_readdata = '0;
        endcase
    end

    assign m_address    = '0;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = m_wr_n_q;
    assign m_writedata  = DATA_W'(m_wd_q);
    assign busy         = busy_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_led_alarm_sequencer.sv
// Scoreboard bench for led_alarm_sequencer: stimulus predicts PIO writes and
// register reads into queues; a negedge monitor pops and compares them.
module tb_led_alarm_sequencer;

    localparam int unsigned LED_W      = 2;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned DEF_PERIOD = 25000000;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_PERIOD  = 2'd1;
    localparam logic [1:0] A_PATTERN = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    localparam logic [31:0] C_EN    = 32'h01;
    localparam logic [31:0] C_AUTO  = 32'h02;
    localparam logic [31:0] C_IE    = 32'h04;
    localparam logic [31:0] C_START = 32'h08;
    localparam logic [31:0] C_STOP  = 32'h10;
    localparam logic [31:0] FULL    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        alarm_trig;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        busy;
    logic        irq;

    led_alarm_sequencer #(
        .LED_W      (LED_W),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .alarm_trig   (alarm_trig),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .busy         (busy),
        .irq          (irq)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } pio_exp_t;

    typedef struct {
        string       name;
        logic [31:0] val;
        logic [31:0] mask;
        logic        busy;
        logic        irq;
        logic        chk_wd;
    } rd_exp_t;

    pio_exp_t pio_q[$];
    rd_exp_t  rd_q[$];
    int       checks   = 0;
    int       errors   = 0;
    int       cyc      = 0;
    int       timeouts = 0;
    bit       tb_end   = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every PIO strobe and every config read against the queues.
    initial begin : monitor
        pio_exp_t e;
        rd_exp_t  r;
        forever begin
            @(negedge clk);
            if (m_chipselect) begin
                checks++;
                if (pio_q.size() == 0) begin
                    errors++;
                    $display("FAIL pio_unexpected: got data=%h at cycle %0d, expected no write",
                             m_writedata, cyc);
                end else begin
                    e = pio_q.pop_front();
                    if (m_writedata !== e.data || cyc != e.cyc || m_write_n !== 1'b0
                        || m_address !== 2'b00) begin
                        errors++;
                        $display("FAIL pio_write: got data=%h cyc=%0d wn=%b addr=%0d, expected data=%h cyc=%0d wn=0 addr=0",
                                 m_writedata, cyc, m_write_n, m_address, e.data, e.cyc);
                    end
                end
            end
            if (s_chipselect && s_write_n && rd_q.size() > 0) begin
                r = rd_q.pop_front();
                checks++;
                if (((s_readdata ^ r.val) & r.mask) != 32'h0 || busy !== r.busy || irq !== r.irq
                    || (r.chk_wd && (m_writedata !== 32'h0 || m_write_n !== 1'b1
                                     || m_chipselect !== 1'b0))) begin
                    errors++;
                    $display("FAIL %s: got rd=%h busy=%b irq=%b wd=%h wn=%b, expected rd=%h (mask %h) busy=%b irq=%b",
                             r.name, s_readdata, busy, irq, m_writedata, m_write_n,
                             r.val, r.mask, r.busy, r.irq);
                end
            end
            if (tb_end) begin
                checks++;
                if (pio_q.size() != 0 || rd_q.size() != 0 || timeouts != 0) begin
                    errors++;
                    $display("FAIL end_state: got %0d pending writes, %0d pending reads, %0d timeouts, expected 0/0/0",
                             pio_q.size(), rd_q.size(), timeouts);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d, output int cap);
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        s_address    = a;
        s_writedata  = d;
        @(posedge clk);
        #1;
        cap          = cyc;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = 32'h0;
    endtask

    task automatic cfg_read(input logic [1:0] a, input string nm, input logic [31:0] v,
                            input logic [31:0] m, input logic b, input logic i,
                            input logic cw);
        rd_exp_t r;
        r.name = nm; r.val = v; r.mask = m; r.busy = b; r.irq = i; r.chk_wd = cw;
        rd_q.push_back(r);
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        s_address    = a;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
    endtask

    // Reference model: pattern phase k starts at c0 + k*(period+1), A on even k.
    function automatic void plan_seq(input int c0, input int p, input logic [1:0] a,
                                     input logic [1:0] b, input int n);
        int       cnt;
        pio_exp_t e;
        cnt = (n == 0) ? 40 : 2 * n;
        for (int k = 0; k < cnt; k++) begin
            e.data = (k % 2 == 0) ? {30'h0, a} : {30'h0, b};
            e.cyc  = c0 + k * (p + 1);
            pio_q.push_back(e);
        end
        if (n != 0) begin
            e.data = 32'h0;
            e.cyc  = c0 + 2 * n * (p + 1);
            pio_q.push_back(e);
        end
    endfunction

    // An abort replaces every not-yet-issued write with a single dark write.
    function automatic void abort_at(input int d);
        pio_exp_t e;
        while (pio_q.size() > 0 && pio_q[pio_q.size()-1].cyc >= d) begin
            void'(pio_q.pop_back());
        end
        e.data = 32'h0;
        e.cyc  = d;
        pio_q.push_back(e);
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 600; i++) begin
            if (pio_q.size() == 0) break;
            tick();
        end
        if (pio_q.size() != 0) timeouts++;
        tick();
        tick();
    endtask

    initial begin : stimulus
        int          cap;
        int          c0;
        int          p;
        int          n;
        int          mode;
        int          d;
        int          e_cyc;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        ie;
        logic [31:0] ctrl;

        reset_n      = 1'b0;
        s_address    = 2'd0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = 32'h0;
        alarm_trig   = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        cfg_read(A_CTRL,    "rst_ctrl",    32'h0,      FULL, 1'b0, 1'b0, 1'b1);
        cfg_read(A_PERIOD,  "rst_period",  DEF_PERIOD, FULL, 1'b0, 1'b0, 1'b1);
        cfg_read(A_PATTERN, "rst_pattern", 32'h0,      FULL, 1'b0, 1'b0, 1'b1);
        cfg_read(A_STATUS,  "rst_status",  32'h0,      FULL, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();

        // Basic two-pair sequence with interrupt enabled.
        cfg_write(A_PERIOD,  32'd4, cap);
        cfg_write(A_PATTERN, 32'h0002_0001, cap);
        cfg_write(A_STATUS,  32'd2, cap);
        cfg_write(A_CTRL,    C_EN | C_IE | C_START, c0);
        plan_seq(c0, 4, 2'b01, 2'b10, 2);
        wait_drain();
        cfg_read(A_STATUS, "seq_done_status", 32'h4000_0000, FULL, 1'b0, 1'b1, 1'b0);
        cfg_write(A_STATUS, 32'd2, cap);
        cfg_read(A_STATUS, "repeat_clears_done", 32'h0, FULL, 1'b0, 1'b0, 1'b0);
        cfg_read(A_CTRL,   "ctrl_pulses_read0", C_EN | C_IE, FULL, 1'b0, 1'b0, 1'b0);

        // Start and stop in one write: stop wins, nothing is issued.
        cfg_write(A_CTRL, C_EN | C_START | C_STOP, cap);
        repeat (8) tick();
        cfg_read(A_STATUS, "stop_wins", 32'h0, FULL, 1'b0, 1'b0, 1'b0);

        // Randomized sequences: plain, redundant start, or stop at a random cycle.
        for (int it = 0; it < 8; it++) begin
            p    = int'($urandom_range(5, 1));
            n    = int'($urandom_range(3, 1));
            a    = 2'($urandom);
            b    = 2'($urandom);
            ie   = 1'($urandom);
            mode = int'($urandom_range(2, 0));
            ctrl = C_EN | (ie ? C_IE : 32'h0);
            cfg_write(A_PERIOD,  32'(p), cap);
            cfg_write(A_PATTERN, {14'h0, b, 14'h0, a}, cap);
            cfg_write(A_STATUS,  32'(n), cap);
            cfg_write(A_CTRL,    ctrl | C_START, c0);
            plan_seq(c0, p, a, b, n);
            e_cyc = c0 + 2 * n * (p + 1);
            if (mode == 1) begin
                cfg_write(A_CTRL, ctrl | C_START, cap);
            end else if (mode == 2) begin
                d = c0 + int'($urandom_range(e_cyc - c0 - 1, 1));
                while (cyc < d - 1) tick();
                cfg_write(A_CTRL, ctrl | C_STOP, cap);
                abort_at(cap);
            end
            wait_drain();
            cfg_read(A_STATUS, "rand_status", 32'h4000_0000,
                     (mode == 2) ? 32'hC000_0000 : FULL, 1'b0, ie, 1'b0);
        end

        // Auto-arm: one start per rising edge, infinite alternation until stop.
        a = 2'($urandom);
        b = 2'($urandom);
        cfg_write(A_STATUS,  32'd0, cap);
        cfg_write(A_PERIOD,  32'd3, cap);
        cfg_write(A_PATTERN, {14'h0, b, 14'h0, a}, cap);
        cfg_write(A_CTRL,    C_EN | C_AUTO, cap);
        tick();
        alarm_trig = 1'b1;
        tick();
        c0 = cyc;
        alarm_trig = 1'b0;
        plan_seq(c0, 3, a, b, 0);
        repeat (5) tick();
        alarm_trig = 1'b1;
        repeat (50) tick();
        cfg_write(A_CTRL, C_EN | C_AUTO | C_STOP, cap);
        abort_at(cap);
        wait_drain();
        repeat (10) tick();
        alarm_trig = 1'b0;
        cfg_read(A_STATUS, "auto_stop_status", 32'h4000_0000, FULL, 1'b0, 1'b0, 1'b0);

        // Clearing enable inside the first pair's B wait counts that pair.
        cfg_write(A_PERIOD,  32'd4, cap);
        cfg_write(A_PATTERN, 32'h0003_0002, cap);
        cfg_write(A_STATUS,  32'd5, cap);
        cfg_write(A_CTRL,    C_EN | C_START, c0);
        plan_seq(c0, 4, 2'b10, 2'b11, 5);
        while (cyc < c0 + 7) tick();
        cfg_write(A_CTRL, 32'h0, cap);
        abort_at(cap);
        wait_drain();
        cfg_read(A_STATUS, "disable_status", 32'h4000_0004, FULL, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the A wait.
        cfg_write(A_PERIOD, 32'd5, cap);
        cfg_write(A_STATUS, 32'd3, cap);
        cfg_write(A_CTRL,   C_EN | C_IE | C_START, c0);
        plan_seq(c0, 5, 2'b10, 2'b11, 3);
        while (cyc < c0 + 3) tick();
        reset_n = 1'b0;
        pio_q.delete();
        cfg_read(A_STATUS, "inrst_status", 32'h0,      FULL, 1'b0, 1'b0, 1'b1);
        cfg_read(A_PERIOD, "inrst_period", DEF_PERIOD, FULL, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        repeat (20) tick();
        cfg_read(A_STATUS,  "postrst_status",  32'h0, FULL, 1'b0, 1'b0, 1'b1);
        cfg_read(A_PATTERN, "postrst_pattern", 32'h0, FULL, 1'b0, 1'b0, 1'b1);
        cfg_write(A_PERIOD, 32'd0, cap);
        cfg_read(A_PERIOD, "period_zero_is_one", 32'd1, FULL, 1'b0, 1'b0, 1'b1);

        tick();
        tb_end = 1'b1;
        repeat (3) tick();
    end

endmodule

// File: doc/led_alarm_sequencer.md
Name: led_alarm_sequencer

Overview:
Avalon-MM controller that owns the 2-bit LED PIO data register and plays an alarm blink sequence on it. The CPU configures it through a small slave register window. A master-side write strobe updates the PIO data register (address 0) on every pattern change. Sits between the alarm logic and the LED PIO; the CPU no longer writes the PIO directly.

Parameters:
LED_W, 2, width of the LED pattern; equals the PIO data width
CNT_W, 32, width of the period counter
DEF_PERIOD, 25000000, reset value of PERIOD (clk cycles per pattern phase)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
s_address  in  2  config register select
s_chipselect  in  1  config slave select
s_write_n  in  1  config write, active-low
s_writedata  in  32  config write data
s_readdata  out  32  config read data; combinational, zero wait states
alarm_trig  in  1  level alarm request from alarm logic
m_address  out  2  PIO address; constant 0
m_chipselect  out  1  PIO write strobe, one cycle per update
m_write_n  out  1  active-low; equals ~m_chipselect
m_writedata  out  32  {zeros, pattern[LED_W-1:0]}
busy  out  1  high while the sequence runs
irq  out  1  level; equals done & CTRL.ie

Behaviour:
- Reset: FSM in IDLE. m_chipselect=0, m_write_n=1, m_writedata=0, busy=0, irq=0, done=0.
- Reset register values: CTRL=0, PERIOD=DEF_PERIOD, PATTERN=0, REPEAT=0.
- Register map (write on s_chipselect & ~s_write_n):
  - 0 CTRL: b0 enable, b1 auto_arm, b2 ie, b3 start (write-1 pulse, reads 0), b4 stop (write-1 pulse, reads 0).
  - 1 PERIOD: [CNT_W-1:0]; a write of 0 stores 1.
  - 2 PATTERN: A=[LED_W-1:0], B=[16+LED_W-1:16].
  - 3 REPEAT: write [15:0] sets the A/B pair count (0 = infinite) and clears done.
  - 3 read: b31 busy, b30 done, [15:0] remaining.
  - Unused bits read 0.
- Start condition, evaluated only in IDLE with enable=1: start pulse, or a rising edge of alarm_trig while auto_arm=1. alarm_trig is registered once for edge detection. A start condition also clears done and loads remaining=REPEAT.
- FSM states and transitions:
  - IDLE: waits for a start condition.
  - WR_A: one-cycle write of A, then WAIT_A.
  - WAIT_A: counts PERIOD cycles, then WR_B.
  - WR_B: one-cycle write of B, then WAIT_B.
  - WAIT_B: counts PERIOD cycles; at the end, if REPEAT≠0, decrement remaining.
    - If the decremented remaining is 0, go to WR_OFF.
    - Otherwise go to WR_A.
  - WR_OFF: one-cycle write of 0, set done, go to IDLE.
- Timing:
  - One pattern phase = 1 write cycle + PERIOD wait cycles.
  - The first PIO write occurs 1 cycle after the start-condition cycle.
  - busy=1 in every state except IDLE.
- PATTERN and PERIOD writes during a sequence take effect at the next WR_x or WAIT_x entry. The running counter is not reloaded mid-phase.
- Stop pulse, or enable cleared, while busy: next state is WR_OFF regardless of phase (including WR_x), so LEDs end dark.
  - done is set. Stop in IDLE has no effect.
- Start pulse while busy: ignored. Start and stop in the same write: stop wins.
- alarm_trig held high: only one start per rising edge.
- remaining saturates at 0; it never wraps.
- Asynchronous reset mid-sequence: immediate return to reset values. No WR_OFF write is issued, and the PIO keeps its own reset value.

Decomposition:
- Shared package led_seq_pkg holds:
  - FSM state enum (IDLE, WR_A, WAIT_A, WR_B, WAIT_B, WR_OFF).
  - Register address constants REG_CTRL=0, REG_PERIOD=1, REG_PATTERN=2, REG_REPEAT=3.
  - CTRL bit indices.
  - PATTERN_B_LSB=16.
- One sub-module, led_seq_timer: loadable down-counter of CNT_W bits with a load input and an expire pulse. The FSM instantiates it for the WAIT states.

Test Plan:
- Reset, then read all registers -> CTRL=0, PERIOD=DEF_PERIOD, PATTERN=0, status=0; no PIO write strobes.
- PERIOD=4, PATTERN A=2'b01 B=2'b10, REPEAT=2, CTRL=enable|start -> PIO writes 1,2,1,2,0 spaced 5 cycles apart; done=1 and busy=0 after the 0 write.
- With ie=1 in the same sequence -> irq rises with done. A write to REPEAT clears done and drops irq.
- auto_arm=1, REPEAT=0, PERIOD=3; pulse alarm_trig, then hold it high for 50 cycles -> exactly one start, infinite A/B alternation; a stop write gives an m_writedata=0 write next cycle, then IDLE.
- Clear enable during WAIT_B of the first pair (REPEAT=5) -> next cycle is a 0 write; remaining reads 4 (one pair counted); busy=0.
- Assert reset_n low mid-WAIT_A -> outputs return to reset values immediately with no further strobes. PERIOD write of 0 reads back 1.
